alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Issue/writeback stage wrapped around the combinational ALU. Accepts one instruction per cycle
//  over a valid/ready handshake and reads operands from an internal register file (or an immediate).
//  Drives registered operands and opcode into the ALU. Writes the ALU result back and latches the ALU flags.
// PARAMETERS
//  BW     16  datapath width; must match the ALU BW
//  NREGS  8   register count, power of 2 >= 2; AW = $clog2(NREGS)
// PORTS
//  clk           in   1    clock, all state on rising edge
//  rst_n         in   1    asynchronous, active-low reset
//  instr_valid   in   1    instruction present
//  instr_ready   out  1    stage can accept; transfer on instr_valid && instr_ready
//  instr_opcode  in   3    ALU opcode: ADD,SUB,AND,OR,XOR,INC,MOVA,MOVB = 0..7
//  instr_dst     in   AW   destination register
//  instr_src_a   in   AW   source A register
//  instr_src_b   in   AW   source B register (ignored when instr_use_imm)
//  instr_use_imm in   1    1: operand B = instr_imm
//  instr_imm     in   BW   immediate operand
//  alu_opcode    out  3    to ALU opcode
//  alu_in_a      out  BW   to ALU in_a
//  alu_in_b      out  BW   to ALU in_b
//  alu_out       in   BW   from ALU out (combinational, same cycle)
//  alu_flags     in   3    from ALU flags {overflow, negative, zero}
//  flags         out  3    status register {overflow, negative, zero}
//  wb_valid      out  1    one-cycle pulse per committed write
//  wb_dst        out  AW   register written
//  wb_data       out  BW   value written
// BEHAVIOUR
//  - Reset (async, rst_n=0): all registers <= 0; ex_valid, wb_valid <= 0; wb_dst, wb_data,
//    alu_opcode, alu_in_a, alu_in_b, flags <= 0. Release is taken synchronously on the next clk edge.
//  - R0 reads as 0 and ignores writes. Reads of R0 never stall and never forward.
//  - Edge N, on accept: EX regs <= {opcode, dst, operand A, operand B}; ex_valid <= 1.
//    Operand B = imm if use_imm, else reg[src_b]. No accept: ex_valid <= 0; EX operands/opcode hold.
//  - Edge N+1, if ex_valid: reg[ex_dst] <= alu_out; flags <= alu_flags; wb_valid <= 1;
//    wb_dst <= ex_dst; wb_data <= alu_out. Otherwise wb_valid <= 0 and flags hold.
//  - Flag latching: flags capture alu_flags verbatim; overflow meaningful only for ADD/SUB.
//  - Latency: accept -> ALU inputs valid 1 cycle; accept -> register/flags updated 2 edges.
//  - Throughput: 1 instruction/cycle; no downstream backpressure; the writeback always completes.
//  - RAW hazard: ex_valid && ex_dst!=0 && (src_a==ex_dst || (!use_imm && src_b==ex_dst)).
//  - Write-before-read of an older instruction through the file needs no stall; the write lands before the read edge.
//  - Reset mid-operation: in-flight EX/WB contents discarded; no register write occurs.
//  - instr_ready never depends combinationally on alu_out.
// CONFIGURATION
//  ALU_BYPASS_EN defined: on a RAW hazard the matching operand is taken from alu_out;
//    instr_ready is constant 1 after reset.
//  ALU_BYPASS_EN undefined: on a RAW hazard instr_ready=0 for exactly one cycle (bubble);
//    the instruction is accepted the following cycle and reads the written value from the file.
// STRUCTURE
//  - alu_pkg holds:
//      opcode enum OP_ADD..OP_MOVB;
//      flag index localparams FLAG_OVF=2, FLAG_NEG=1, FLAG_ZERO=0;
//      typedef ex_reg_t {opcode, dst, a, b}.
//  - Sub-module alu_reg_file:
//      NREGS x BW, 2 async read ports, 1 sync write port;
//      R0 hardwired to 0; async active-low reset clears all entries.
//  - Hazard detection, operand mux and EX/WB registers live in the top.
// TESTING
//  1. Reset: pulse rst_n low mid-clock -> outputs 0 immediately; MOVA r1 then reads wb_data=0, flags=3'b001.
//  2. MOVB r1,#0x0005 -> cycle after accept alu_in_b=0x0005, alu_opcode=7; next cycle wb_valid=1, wb_dst=1, wb_data=5, flags=000.
//  3. MOVB r1,#0x7FFF then INC r2,r1 back-to-back:
//       with ALU_BYPASS_EN, alu_in_a=0x7FFF and no stall;
//       without it, instr_ready=0 for 1 cycle;
//       both: wb_data=0x8000, flags=3'b010.
//  4. r1=0x7FFF, ADD r3,r1,r1 -> wb_data=0xFFFE, flags=3'b110.
//     Then SUB r4,r3,r3 -> wb_data=0, flags=3'b001.
//  5. MOVB r0,#5 then MOVA r5,r0 -> no stall, wb_data=0, flags=3'b001.
//  6. Accept ADD r6; drop rst_n the next cycle -> wb_valid stays 0; after release r6 reads 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand/writeback stage: opcodes, flag bit positions and the EX register layout.
package alu_pkg;

  localparam int ALU_BW    = 16;
  localparam int ALU_NREGS = 8;
  localparam int ALU_AW    = $clog2(ALU_NREGS);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_INC  = 3'd5,
    OP_MOVA = 3'd6,
    OP_MOVB = 3'd7
  } op_t;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  // EX register contents; field widths track ALU_BW / ALU_AW, so the stage parameters must match them.
  typedef struct packed {
    op_t               opcode;
    logic [ALU_AW-1:0] dst;
    logic [ALU_BW-1:0] a;
    logic [ALU_BW-1:0] b;
  } ex_reg_t;

  // A source operand collides with the instruction in EX; R0 never collides.
  function automatic logic raw_hit(input logic              ex_vld,
                                   input logic [ALU_AW-1:0] ex_dst,
                                   input logic [ALU_AW-1:0] src);
    return ex_vld && (ex_dst != '0) && (src == ex_dst);
  endfunction

endpackage

// File: rtl/alu_reg_file.sv
// NREGS x BW register file: two asynchronous read ports, one synchronous write port, R0 hardwired to zero.
module alu_reg_file
  import alu_pkg::*;
#(
  parameter int BW    = ALU_BW,
  parameter int NREGS = ALU_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  output logic [BW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [BW-1:0] rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data
);

  logic [BW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue/writeback stage around a combinational ALU: operand fetch, RAW hazard handling, EX and WB registers.
// Build option ALU_BYPASS_EN: forward alu_out on a RAW hazard instead of inserting a one-cycle bubble.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int BW    = ALU_BW,
  parameter int NREGS = ALU_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_opcode,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_src_a,
  input  logic [AW-1:0] instr_src_b,
  input  logic          instr_use_imm,
  input  logic [BW-1:0] instr_imm,
  output logic [2:0]    alu_opcode,
  output logic [BW-1:0] alu_in_a,
  output logic [BW-1:0] alu_in_b,
  input  logic [BW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  output logic [2:0]    flags,
  output logic          wb_valid,
  output logic [AW-1:0] wb_dst,
  output logic [BW-1:0] wb_data
);

  ex_reg_t       ex_p1;
  logic          vld_p1;
  logic [BW-1:0] rf_a;
  logic [BW-1:0] rf_b;
  logic [BW-1:0] opnd_a;
  logic [BW-1:0] opnd_b;
  logic          hit_a;
  logic          hit_b;
  logic          accept;

  alu_reg_file #(.BW(BW), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr_a(instr_src_a),
    .rd_data_a(rf_a),
    .rd_addr_b(instr_src_b),
    .rd_data_b(rf_b),
    .wr_en    (vld_p1),
    .wr_addr  (ex_p1.dst),
    .wr_data  (alu_out)
  );

  // Only the instruction sitting in EX can be unwritten; anything older has already landed in the file.
  assign hit_a = raw_hit(vld_p1, ex_p1.dst, instr_src_a);
  assign hit_b = !instr_use_imm && raw_hit(vld_p1, ex_p1.dst, instr_src_b);

`ifdef ALU_BYPASS_EN
  assign instr_ready = 1'b1;
  assign opnd_a      = hit_a ? alu_out : rf_a;
  assign opnd_b      = instr_use_imm ? instr_imm : (hit_b ? alu_out : rf_b);
`else
  // The bubble lets the EX result reach the file before the operand read; ready never sees alu_out.
  assign instr_ready = !(hit_a || hit_b);
  assign opnd_a      = rf_a;
  assign opnd_b      = instr_use_imm ? instr_imm : rf_b;
`endif

  assign accept = instr_valid && instr_ready;

  // Stage boundary: issue -> EX (drives the ALU inputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      ex_p1  <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        ex_p1.opcode <= op_t'(instr_opcode);
        ex_p1.dst    <= instr_dst;
        ex_p1.a      <= opnd_a;
        ex_p1.b      <= opnd_b;
      end
    end
  end

  assign alu_opcode = ex_p1.opcode;
  assign alu_in_a   = ex_p1.a;
  assign alu_in_b   = ex_p1.b;

  // Stage boundary: EX -> WB (register file write happens on the same edge inside u_rf)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
      flags    <= '0;
    end else begin
      wb_valid <= vld_p1;
      if (vld_p1) begin
        wb_dst  <= ex_p1.dst;
        wb_data <= alu_out;
        flags   <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed + scoreboard bench for alu_operand_stage with a behavioural ALU attached.
module tb_alu_operand_stage;

  localparam int BW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_opcode = '0;
  logic [AW-1:0] instr_dst = '0;
  logic [AW-1:0] instr_src_a = '0;
  logic [AW-1:0] instr_src_b = '0;
  logic          instr_use_imm = 1'b0;
  logic [BW-1:0] instr_imm = '0;
  logic [2:0]    alu_opcode;
  logic [BW-1:0] alu_in_a;
  logic [BW-1:0] alu_in_b;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic [2:0]    flags;
  logic          wb_valid;
  logic [AW-1:0] wb_dst;
  logic [BW-1:0] wb_data;

  typedef struct {
    logic [AW-1:0] dst;
    logic [BW-1:0] data;
    logic [2:0]    fl;
  } exp_t;

  exp_t          sb_q[$];
  logic [BW-1:0] sh [8];
  int            total = 0;
  int            bad = 0;
  int            stalls;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_dst    (instr_dst),
    .instr_src_a  (instr_src_a),
    .instr_src_b  (instr_src_b),
    .instr_use_imm(instr_use_imm),
    .instr_imm    (instr_imm),
    .alu_opcode   (alu_opcode),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .flags        (flags),
    .wb_valid     (wb_valid),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data)
  );

  function automatic logic [BW-1:0] alu_res(input logic [2:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a + 16'd1;
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  function automatic logic [2:0] alu_flg(input logic [2:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          ovf;
    r   = alu_res(op, a, b);
    ovf = 1'b0;
    if (op == 3'd0) ovf = (a[BW-1] == b[BW-1]) && (r[BW-1] != a[BW-1]);
    if (op == 3'd1) ovf = (a[BW-1] != b[BW-1]) && (r[BW-1] != a[BW-1]);
    return {ovf, r[BW-1], (r == '0)};
  endfunction

  assign alu_out   = alu_res(alu_opcode, alu_in_a, alu_in_b);
  assign alu_flags = alu_flg(alu_opcode, alu_in_a, alu_in_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writeback monitor: every committed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_wb_dst", 32'(wb_dst), 32'(e.dst));
        chk("sb_wb_data", 32'(wb_data), 32'(e.data));
        chk("sb_flags", 32'(flags), 32'(e.fl));
      end
    end
  end

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one instruction, wait (bounded) for acceptance, push its expected writeback. Returns at accept edge + 1.
  task automatic issue(input logic [2:0] op, input int dst, input int sa, input int sb,
                       input logic use_imm, input logic [BW-1:0] imm, output int nstall);
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    exp_t          e;
    instr_opcode  = op;
    instr_dst     = AW'(dst);
    instr_src_a   = AW'(sa);
    instr_src_b   = AW'(sb);
    instr_use_imm = use_imm;
    instr_imm     = imm;
    instr_valid   = 1'b1;
    nstall        = 0;
    a = sh[sa];
    b = use_imm ? imm : sh[sb];
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (instr_ready) break;
      nstall++;
    end
    chk("issue_ready", 32'(instr_ready), 32'd1);
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.dst  = AW'(dst);
    e.data = alu_res(op, a, b);
    e.fl   = alu_flg(op, a, b);
    sb_q.push_back(e);
    if (dst != 0) sh[dst] = e.data;
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic clear_model();
    sb_q.delete();
    for (int i = 0; i < 8; i++) sh[i] = '0;
  endtask

  initial begin
    clear_model();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MOVB r1,#5
    issue(3'd7, 1, 0, 0, 1'b1, 16'h0005, stalls);
    chk("t2_alu_in_b", 32'(alu_in_b), 32'h5);
    chk("t2_alu_opcode", 32'(alu_opcode), 32'd7);
    idle(1);
    chk("t2_wb_valid", 32'(wb_valid), 32'd1);
    chk("t2_wb_dst", 32'(wb_dst), 32'd1);
    chk("t2_wb_data", 32'(wb_data), 32'h5);
    chk("t2_flags", 32'(flags), 32'd0);
    idle(1);

    // Mid-clock reset pulse clears everything at once
    @(negedge clk) rst_n = 1'b0;
    clear_model();
    #1;
    chk("t1_wb_data", 32'(wb_data), 32'd0);
    chk("t1_wb_dst", 32'(wb_dst), 32'd0);
    chk("t1_alu_in_b", 32'(alu_in_b), 32'd0);
    chk("t1_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("t1_flags", 32'(flags), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd6, 2, 1, 0, 1'b0, 16'h0, stalls);
    idle(1);
    chk("t1_mova_data", 32'(wb_data), 32'd0);
    chk("t1_mova_flags", 32'(flags), 32'b001);

    // Back-to-back RAW: MOVB r1,#7FFF ; INC r2,r1
    issue(3'd7, 1, 0, 0, 1'b1, 16'h7FFF, stalls);
    issue(3'd5, 2, 1, 0, 1'b0, 16'h0, stalls);
`ifdef ALU_BYPASS_EN
    chk("t3_stalls", 32'(stalls), 32'd0);
`else
    chk("t3_stalls", 32'(stalls), 32'd1);
`endif
    chk("t3_alu_in_a", 32'(alu_in_a), 32'h7FFF);
    idle(1);
    chk("t3_wb_data", 32'(wb_data), 32'h8000);
    chk("t3_flags", 32'(flags), 32'b010);

    // ADD r3,r1,r1 ; SUB r4,r3,r3
    issue(3'd0, 3, 1, 1, 1'b0, 16'h0, stalls);
    idle(1);
    chk("t4_add_data", 32'(wb_data), 32'hFFFE);
    chk("t4_add_flags", 32'(flags), 32'b110);
    issue(3'd1, 4, 3, 3, 1'b0, 16'h0, stalls);
    idle(1);
    chk("t4_sub_data", 32'(wb_data), 32'd0);
    chk("t4_sub_flags", 32'(flags), 32'b001);

    // R0 ignores writes and never stalls
    issue(3'd7, 0, 0, 0, 1'b1, 16'h0005, stalls);
    issue(3'd6, 5, 0, 0, 1'b0, 16'h0, stalls);
    chk("t5_stalls", 32'(stalls), 32'd0);
    idle(1);
    chk("t5_wb_data", 32'(wb_data), 32'd0);
    chk("t5_flags", 32'(flags), 32'b001);

    // Random back-to-back traffic, checked by the scoreboard
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom), stalls);
    end
    idle(3);
    chk("rand_drained", 32'(sb_q.size()), 32'd0);

    // Reset while an instruction is in EX: no writeback, file cleared
    issue(3'd0, 6, 1, 1, 1'b0, 16'h0, stalls);
    @(negedge clk) rst_n = 1'b0;
    clear_model();
    #1;
    chk("t6_wb_valid_a", 32'(wb_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_wb_valid_b", 32'(wb_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_wb_valid_c", 32'(wb_valid), 32'd0);
    issue(3'd6, 7, 6, 0, 1'b0, 16'h0, stalls);
    idle(1);
    chk("t6_r6_data", 32'(wb_data), 32'd0);
    idle(2);
    chk("final_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
